md_sequencer: RTL and testbench
===============================

# md_sequencer

Multi-cycle multiply/divide unit and HI/LO register owner for the pipelined MIPS core. It sits in the E stage, accepts the decoder's 4-bit HiLoOp together with the forwarded rs/rt operands, and sequences mult/multu/div/divu over a fixed number of cycles. It serves mfhi/mflo/mthi/mtlo, and exports busy/stall status to the hazard unit so that dependent HI/LO instructions are held in D.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  E-stage instruction is valid and carries a HiLoOp
- cancel  in  1  E-stage instruction is being flushed this cycle (exception/eret)
- HiLoOp  in  4  `NOP_FOR_HI_LO=0, `MULT_OP=1, `MULTU_OP=2, `DIV_OP=3, `DIVU_OP=4, `MFHI_OP=5, `MFLO_OP=6, `MTHI_OP=7, `MTLO_OP=8
- A  in  32  rs operand (forwarded)
- B  in  32  rt operand (forwarded)
- busy  out  1  multi-cycle operation in progress (registered)
- md_stall  out  1  busy | (start & ~cancel & HiLoOp in {1..4}); the hazard unit stalls D-stage HiLo instructions on it
- hi  out  32  HI register
- lo  out  32  LO register
- hilo_out  out  32  hi when HiLoOp==MFHI, lo when HiLoOp==MFLO, else 0 (combinational)

## Operation
- States: IDLE, MUL, DIV. Counter cnt has width $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
- Accept condition: state==IDLE & start & ~cancel. Every other request is ignored. This includes a request while busy; the pipeline guarantees that case does not occur.
- MULT/MULTU accepted:
  - compute the 64-bit product immediately from latched A/B: MULT is signed, MULTU is unsigned
  - store the result in res_hi/res_lo; cnt←MULT_CYCLES; state←MUL
- DIV/DIVU accepted:
  - res_lo = quotient, res_hi = remainder
  - DIV is signed, truncating toward zero; the remainder takes the sign of the dividend
  - DIVU is unsigned
  - cnt←DIV_CYCLES; state←DIV
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0
  - B==0: no commit at completion; HI/LO stay unchanged, but the busy timing is identical
- MUL/DIV states:
  - cnt decrements each cycle
  - on the edge where cnt==1: hi←res_hi, lo←res_lo (unless divide-by-zero); state←IDLE
- MTHI/MTLO accepted: hi←A (or lo←A) at the next edge; single cycle; busy stays 0.
- MFHI/MFLO: pure read via hilo_out; no state change. The value reflects HI/LO as of the current cycle, i.e. including a write committed at the previous edge.
- cancel is used only at acceptance. Once an operation is in MUL/DIV it runs to completion regardless of cancel, because it was issued by an older, committed instruction.
- busy = (state != IDLE).

## Timing
- Reset (rst_n low, asynchronous):
  - state=IDLE, cnt=0, busy=0, hi=0, lo=0, res_hi=res_lo=0
  - md_stall follows its combinational definition
- Start accepted at edge t0: busy is high for exactly N cycles after t0 (N=MULT_CYCLES or DIV_CYCLES). HI/LO are updated at edge t0+N, the same edge at which busy falls.
- md_stall asserts in the start cycle itself (combinationally), then tracks busy. It is deasserted in the first cycle in which HI/LO hold the new result.
- A new multi-cycle op is accepted in the cycle busy is 0. Back-to-back ops are spaced at least N+1 cycles apart.
- rst_n asserted mid-operation: the op is aborted immediately and the partial result is discarded. HI/LO and all state return to 0.
- Simultaneous start and cancel: treated as no request; no stall; no state change.

## Test plan
- Reset, then MULT A=0xFFFFFFFD (-3), B=5 → busy for 5 cycles, md_stall high from the start cycle; after busy falls hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU A=0xFFFFFFFF, B=2 → hi=0x00000001, lo=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7), B=2 → busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU A=7, B=2 → lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Preload hi=0x11, lo=0x22 via MTHI/MTLO. Then DIVU A=7, B=0 → busy 10 cycles; hi=0x11, lo=0x22 unchanged. MFHI → hilo_out=0x11.
- MULT with start=1 and cancel=1 in the same cycle → busy stays 0, md_stall stays 0, HI/LO unchanged. cancel pulsed during an accepted MULT → result still commits at t0+5.
- During a busy DIV, drive MTHI A=0xDEAD and a second MULT → both ignored; DIV result commits on schedule and busy falls at t0+10.
- Deassert rst_n at busy cycle 3 of MULT → busy=0, hi=lo=0 immediately (asynchronously). After release, a fresh MULTU 3×4 → lo=12, hi=0.

Source files
------------

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer that owns the HI/LO register pair.
// Results are computed at acceptance and committed once the busy window has elapsed.
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        cancel,
  input  logic [3:0]  HiLoOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] hilo_out
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [31:0]      hi_reg, hi_next;
  logic [31:0]      lo_reg, lo_next;
  logic [31:0]      res_hi_reg, res_hi_next;
  logic [31:0]      res_lo_reg, res_lo_next;
  logic             dz_reg, dz_next;

  logic        accept;
  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, divisor, q_mag, r_mag, quot, rem;

  assign accept = (state_reg == ST_IDLE) && start && !cancel;

  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide on magnitudes so the INT_MIN / -1 case wraps to INT_MIN without relying on tool behaviour.
  assign a_neg   = (HiLoOp == OP_DIV) && A[31];
  assign b_neg   = (HiLoOp == OP_DIV) && B[31];
  assign a_mag   = a_neg ? -A : A;
  assign b_mag   = b_neg ? -B : B;
  assign divisor = (B == 32'd0) ? 32'd1 : b_mag;
  assign q_mag   = a_mag / divisor;
  assign r_mag   = a_mag % divisor;
  assign quot    = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem     = a_neg ? -r_mag : r_mag;

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    res_hi_next = res_hi_reg;
    res_lo_next = res_lo_reg;
    dz_next     = dz_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          case (HiLoOp)
            OP_MULT, OP_MULTU: begin
              {res_hi_next, res_lo_next} = (HiLoOp == OP_MULT) ? prod_s : prod_u;
              dz_next    = 1'b0;
              cnt_next   = CNT_W'(MULT_CYCLES);
              state_next = ST_MUL;
            end
            OP_DIV, OP_DIVU: begin
              res_hi_next = rem;
              res_lo_next = quot;
              dz_next     = (B == 32'd0);
              cnt_next    = CNT_W'(DIV_CYCLES);
              state_next  = ST_DIV;
            end
            OP_MTHI: hi_next = A;
            OP_MTLO: lo_next = A;
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        if (cnt_reg == CNT_W'(1)) begin
          if (!dz_reg) begin
            hi_next = res_hi_reg;
            lo_next = res_lo_reg;
          end
          cnt_next   = '0;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      hi_reg     <= 32'd0;
      lo_reg     <= 32'd0;
      res_hi_reg <= 32'd0;
      res_lo_reg <= 32'd0;
      dz_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      res_hi_reg <= res_hi_next;
      res_lo_reg <= res_lo_next;
      dz_reg     <= dz_next;
    end
  end

  assign busy     = (state_reg != ST_IDLE);
  assign md_stall = busy || (start && !cancel && (HiLoOp >= OP_MULT) && (HiLoOp <= OP_DIVU));
  assign hi       = hi_reg;
  assign lo       = lo_reg;

  always_comb begin
    hilo_out = 32'd0;
    if (HiLoOp == OP_MFHI) hilo_out = hi_reg;
    else if (HiLoOp == OP_MFLO) hilo_out = lo_reg;
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: multiply/divide timing, HI/LO moves, cancel and async reset.
module tb_md_sequencer;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic [3:0]  HiLoOp = 4'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        busy, md_stall;
  logic [31:0] hi, lo, hilo_out;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cancel(cancel), .HiLoOp(HiLoOp),
    .A(A), .B(B), .busy(busy), .md_stall(md_stall), .hi(hi), .lo(lo), .hilo_out(hilo_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 1: pulse cancel at busy cycle k; mode 2: drive MTHI then MULT starting at busy cycle k.
  task automatic do_op(input string nm, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int n, input logic [31:0] eh, input logic [31:0] el,
                       input int mode, input int k);
    start = 1'b1; HiLoOp = op; A = a; B = b;
    #1 chk({nm, "_stall_start"}, md_stall, 1);
    chk({nm, "_idle_before"}, busy, 0);
    step();
    start = 1'b0; HiLoOp = OP_NOP; A = 32'd0; B = 32'd0;
    for (int i = 0; i < n; i++) begin
      chk({nm, "_busy"}, busy, 1);
      chk({nm, "_stall"}, md_stall, 1);
      if (i == n - 1) begin
        chk({nm, "_hi_hold"}, hi, hi_m);
        chk({nm, "_lo_hold"}, lo, lo_m);
      end
      if (mode == 1 && i == k) cancel = 1'b1;
      if (mode == 1 && i == k + 1) cancel = 1'b0;
      if (mode == 2 && i == k) begin start = 1'b1; HiLoOp = OP_MTHI; A = 32'h0000DEAD; end
      if (mode == 2 && i == k + 1) begin HiLoOp = OP_MULT; A = 32'd3; B = 32'd3; end
      if (mode == 2 && i == k + 2) begin start = 1'b0; HiLoOp = OP_NOP; A = 32'd0; B = 32'd0; end
      step();
    end
    chk({nm, "_busy_fall"}, busy, 0);
    chk({nm, "_stall_fall"}, md_stall, 0);
    chk({nm, "_hi"}, hi, eh);
    chk({nm, "_lo"}, lo, el);
    hi_m = eh; lo_m = el;
    $display("op %s a=%h b=%h -> hi=%h lo=%h", nm, a, b, hi, lo);
  endtask

  task automatic do_mt(input string nm, input logic [3:0] op, input logic [31:0] a);
    start = 1'b1; HiLoOp = op; A = a;
    #1 chk({nm, "_stall"}, md_stall, 0);
    step();
    start = 1'b0; HiLoOp = OP_NOP; A = 32'd0;
    if (op == OP_MTHI) hi_m = a; else lo_m = a;
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_hi"}, hi, hi_m);
    chk({nm, "_lo"}, lo, lo_m);
    $display("op %s a=%h -> hi=%h lo=%h", nm, a, hi, lo);
  endtask

  initial begin
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_stall", md_stall, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_hilo_out", hilo_out, 0);
    rst_n = 1'b1;
    step();

    do_op("mult_neg3x5", OP_MULT, 32'hFFFFFFFD, 32'd5, 5, 32'hFFFFFFFF, 32'hFFFFFFF1, 0, 0);
    do_op("multu_max_x2", OP_MULTU, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE, 0, 0);
    do_op("div_neg7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0);
    do_op("divu_7_2", OP_DIVU, 32'd7, 32'd2, 10, 32'd1, 32'd3, 0, 0);
    do_op("div_min_neg1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000, 0, 0);

    do_mt("mthi_11", OP_MTHI, 32'h11);
    do_mt("mtlo_22", OP_MTLO, 32'h22);
    do_op("divu_by_zero", OP_DIVU, 32'd7, 32'd0, 10, 32'h11, 32'h22, 0, 0);

    HiLoOp = OP_MFHI;
    #1 chk("mfhi_out", hilo_out, 32'h11);
    HiLoOp = OP_MFLO;
    #1 chk("mflo_out", hilo_out, 32'h22);
    HiLoOp = OP_NOP;
    #1 chk("nop_hilo_out", hilo_out, 0);
    $display("op mfhi/mflo -> 11/22 read back");

    start = 1'b1; cancel = 1'b1; HiLoOp = OP_MULT; A = 32'd2; B = 32'd3;
    #1 chk("cancel_start_stall", md_stall, 0);
    step();
    start = 1'b0; cancel = 1'b0; HiLoOp = OP_NOP;
    for (int i = 0; i < 6; i++) begin
      chk("cancel_start_busy", busy, 0);
      step();
    end
    chk("cancel_start_hi", hi, hi_m);
    chk("cancel_start_lo", lo, lo_m);
    $display("op mult+cancel -> ignored hi=%h lo=%h", hi, lo);

    do_op("mult_cancel_mid", OP_MULT, 32'd6, 32'd7, 5, 32'd0, 32'h2A, 1, 1);
    do_op("div_with_intrude", OP_DIV, 32'd100, 32'd7, 10, 32'd2, 32'hE, 2, 3);
    for (int i = 0; i < 3; i++) begin
      chk("intrude_no_followon", busy, 0);
      step();
    end

    start = 1'b1; HiLoOp = OP_MULT; A = 32'h10; B = 32'h10;
    step();
    start = 1'b0; HiLoOp = OP_NOP; A = 32'd0; B = 32'd0;
    step();
    step();
    chk("rst_mid_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_busy", busy, 0);
    chk("rst_mid_hi", hi, 0);
    chk("rst_mid_lo", lo, 0);
    #2 rst_n = 1'b1;
    hi_m = 32'd0; lo_m = 32'd0;
    step();
    for (int i = 0; i < 6; i++) begin
      chk("rst_mid_no_commit_lo", lo, 0);
      step();
    end
    $display("op async reset mid-mult -> hi=%h lo=%h busy=%b", hi, lo, busy);
    do_op("multu_3x4", OP_MULTU, 32'd3, 32'd4, 5, 32'd0, 32'd12, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
